pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage core (F, D, E, M, W). It decides every cycle whether each pipeline register (if2id, id2ex, ex2mem, mem2wb) holds, passes or is cleared. Inputs are the multi-cycle divider, the instruction/data memory handshakes, the hazard unit's load-use flag and the MEM-stage exception. It replaces the hard-wired always-enable on the stage registers with one arbitrated source of truth.

---
 rtl/pipe_ctrl_pkg.sv | 71 +++++++
 rtl/pipe_perf_cnt.sv | 46 ++++
 rtl/pipe_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline stall/flush sequencer:
//   pipe_state_e : sequencer state encoding
//   pipe_ctl_t   : packed stall/flush/redirect vector, one bit per control line
//   pipe_dec_t   : result of one priority evaluation (next state + controls)
//   run_priority : the RUN-state arbitration, reused when MEM_WAIT resolves
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        DIV_WAIT  = 2'd2,
        EXC_FLUSH = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
        logic exc_redirect;
    } pipe_ctl_t;

    typedef struct packed {
        pipe_state_e nxt;
        pipe_ctl_t   ctl;
    } pipe_dec_t;

    // Bit order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m flush_w exc_redirect
    localparam pipe_ctl_t NO_STALL    = 9'b0000_0000_0;
    localparam pipe_ctl_t CTL_EXC     = 9'b0000_1110_1;
    localparam pipe_ctl_t CTL_MEM     = 9'b1111_0001_0;
    localparam pipe_ctl_t CTL_DIV     = 9'b1110_0010_0;
    localparam pipe_ctl_t CTL_IFETCH  = 9'b1000_1000_0;
    localparam pipe_ctl_t CTL_LOADUSE = 9'b1100_0100_0;
    localparam pipe_ctl_t CTL_KILL    = 9'b0000_1100_0;

    // Highest-priority cause wins; the caller masks mem_stall when a pending
    // data access completes so whatever was queued behind it is honoured.
    function automatic pipe_dec_t run_priority(input logic exc,
                                               input logic mem_stall,
                                               input logic div_start,
                                               input logic if_stall,
                                               input logic load_use);
        pipe_dec_t d;
        d.nxt = RUN;
        d.ctl = NO_STALL;
        if (exc) begin
            d.nxt = EXC_FLUSH;
            d.ctl = CTL_EXC;
        end else if (mem_stall) begin
            d.nxt = MEM_WAIT;
            d.ctl = CTL_MEM;
        end else if (div_start) begin
            d.nxt = DIV_WAIT;
            d.ctl = CTL_DIV;
        end else if (if_stall) begin
            d.ctl = CTL_IFETCH;
        end else if (load_use) begin
            d.ctl = CTL_LOADUSE;
        end
        return d;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Free-running stall performance counters, wrapping at all-ones.
// Ports:
//   clk             core clock
//   rst             asynchronous active-low reset, clears both counters
//   stall_inc_i     count this cycle in stall_cnt_o (front-end stalled)
//   mem_inc_i       count this cycle in mem_stall_cnt_o (memory stall driven)
//   stall_cnt_o     cycles with StallF high
//   mem_stall_cnt_o cycles spent waiting on a data access
// -----------------------------------------------------------------------------
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc_i,
    input  logic             mem_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q,   mem_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        if (stall_inc_i) stall_cnt_d = stall_cnt_q + 1'b1;
        if (mem_inc_i)   mem_cnt_d   = mem_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            mem_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
        end
    end

    assign stall_cnt_o     = stall_cnt_q;
    assign mem_stall_cnt_o = mem_cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush sequencer for the five-stage core. Decides every cycle,
// combinationally from state and inputs, whether each pipeline register holds,
// passes or is cleared.
//
// Optional feature macro: PIPE_PERF_CNT_EN adds StallCnt / MemStallCnt.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-low reset
//   InstReqF / InstOkF       fetch handshake
//   DataReqM / DataOkM       MEM-stage data handshake
//   DivStartE / DivDoneE     iterative divider start level / done pulse
//   LoadUseD                 load-use hazard in D
//   ExcValidM                exception in MEM
//   StallF/D/E/M             hold PC / if2id / id2ex / ex2mem
//   FlushD/E/M/W             clear if2id / id2ex / ex2mem / mem2wb
//   ExcRedirectF             load exception vector into the PC
//   StallCnt, MemStallCnt    performance counters (PIPE_PERF_CNT_EN only)
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// RUN       | normal issue; full priority arbitration every cycle
// MEM_WAIT  | data access outstanding; whole pipe frozen, W fed bubbles
// DIV_WAIT  | divider iterating; F/D/E frozen, M fed bubbles
// EXC_FLUSH | one cycle after redirect; kills the wrong-path fetch in D/E
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InstReqF,
    input  logic             InstOkF,
    input  logic             DataReqM,
    input  logic             DataOkM,
    input  logic             DivStartE,
    input  logic             DivDoneE,
    input  logic             LoadUseD,
    input  logic             ExcValidM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             ExcRedirectF
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] MemStallCnt
`endif
);

    pipe_state_e state_q, state_d;
    pipe_ctl_t   ctl, ctl_o;
    pipe_dec_t   run_dec, resume_dec;

    assign run_dec    = run_priority(ExcValidM, DataReqM & ~DataOkM, DivStartE,
                                     InstReqF & ~InstOkF, LoadUseD);
    // Data access just completed: same arbitration without the memory term.
    assign resume_dec = run_priority(ExcValidM, 1'b0, DivStartE,
                                     InstReqF & ~InstOkF, LoadUseD);

    always_comb begin
        state_d = state_q;
        ctl     = NO_STALL;
        unique case (state_q)
            RUN: begin
                state_d = run_dec.nxt;
                ctl     = run_dec.ctl;
            end
            MEM_WAIT: begin
                if (!DataOkM) begin
                    ctl = CTL_MEM;
                end else begin
                    state_d = resume_dec.nxt;
                    ctl     = resume_dec.ctl;
                end
            end
            DIV_WAIT: begin
                // M holds a bubble here, so ExcValidM cannot occur.
                if (!DivDoneE) begin
                    ctl = CTL_DIV;
                end else begin
                    state_d = RUN;
                end
            end
            EXC_FLUSH: begin
                ctl     = CTL_KILL;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // Outputs must read zero for as long as reset is held, not just after it.
    assign ctl_o = rst ? ctl : NO_STALL;

    assign StallF       = ctl_o.stall_f;
    assign StallD       = ctl_o.stall_d;
    assign StallE       = ctl_o.stall_e;
    assign StallM       = ctl_o.stall_m;
    assign FlushD       = ctl_o.flush_d;
    assign FlushE       = ctl_o.flush_e;
    assign FlushM       = ctl_o.flush_m;
    assign FlushW       = ctl_o.flush_w;
    assign ExcRedirectF = ctl_o.exc_redirect;

`ifdef PIPE_PERF_CNT_EN
    // StallM is driven only by the memory-stall pattern, so it marks exactly
    // the cycles spent waiting on a data access, including the request cycle.
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk             (clk),
        .rst             (rst),
        .stall_inc_i     (ctl_o.stall_f),
        .mem_inc_i       (ctl_o.stall_m),
        .stall_cnt_o     (StallCnt),
        .mem_stall_cnt_o (MemStallCnt)
    );
`else
    // CNT_W only shapes the counters; keep the parameter referenced and sane.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic InstReqF = 0, InstOkF = 0, DataReqM = 0, DataOkM = 0;
    logic DivStartE = 0, DivDoneE = 0, LoadUseD = 0, ExcValidM = 0;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, ExcRedirectF;
`ifdef PIPE_PERF_CNT_EN
    logic [2:0] StallCnt, MemStallCnt;
`endif

    int checks   = 0;
    int failures = 0;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,ExcRedirectF}
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_EXC  = 9'b000011101;
    localparam logic [8:0] E_MEM  = 9'b111100010;
    localparam logic [8:0] E_DIV  = 9'b111000100;
    localparam logic [8:0] E_IF   = 9'b100010000;
    localparam logic [8:0] E_LU   = 9'b110001000;
    localparam logic [8:0] E_KILL = 9'b000011000;

    wire [8:0] obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, ExcRedirectF};

    pipe_stall_ctrl #(.CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .InstReqF     (InstReqF),
        .InstOkF      (InstOkF),
        .DataReqM     (DataReqM),
        .DataOkM      (DataOkM),
        .DivStartE    (DivStartE),
        .DivDoneE     (DivDoneE),
        .LoadUseD     (LoadUseD),
        .ExcValidM    (ExcValidM),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .FlushW       (FlushW),
        .ExcRedirectF (ExcRedirectF)
`ifdef PIPE_PERF_CNT_EN
        ,
        .StallCnt     (StallCnt),
        .MemStallCnt  (MemStallCnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the pipe is either free, waiting on data, waiting on
    // the divider, or in the single kill cycle that follows a redirect.
    bit m_mem, m_div, m_kill;
    bit n_mem, n_div, n_kill;
    logic [2:0] m_scnt, m_mcnt;

    task automatic model_eval(output logic [8:0] e);
        n_mem = 0; n_div = 0; n_kill = 0; e = E_NONE;
        if (m_kill)                                 e = E_KILL;
        else if (m_div) begin
            if (!DivDoneE) begin e = E_DIV; n_div = 1; end
        end
        else if (m_mem && !DataOkM)           begin e = E_MEM; n_mem = 1; end
        else if (ExcValidM)                   begin e = E_EXC; n_kill = 1; end
        else if (!m_mem && DataReqM && !DataOkM) begin e = E_MEM; n_mem = 1; end
        else if (DivStartE)                   begin e = E_DIV; n_div = 1; end
        else if (InstReqF && !InstOkF)              e = E_IF;
        else if (LoadUseD)                          e = E_LU;
    endtask

    task automatic set_in(input logic ireq, iok, dreq, dok, dstart, ddone, lu, exc);
        InstReqF = ireq; InstOkF = iok; DataReqM = dreq; DataOkM = dok;
        DivStartE = dstart; DivDoneE = ddone; LoadUseD = lu; ExcValidM = exc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_mem = 0; m_div = 0; m_kill = 0; m_scnt = 0; m_mcnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            #4;
            checks++;
            if (obs !== E_NONE) begin
                failures++;
                $display("FAIL reset_outputs got=%b want=%b", obs, E_NONE);
            end
            step();
        end
        checks++;
        if (dut.state_q !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d want=0", dut.state_q);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (StallCnt !== 3'd0 || MemStallCnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", StallCnt, MemStallCnt);
        end
`endif
    endtask

    task automatic test_load_use();
        apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        #4;
        checks++;
        if (obs !== E_LU) begin
            failures++;
            $display("FAIL load_use got=%b want=%b", obs, E_LU);
        end
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE || dut.state_q !== 2'd0) begin
            failures++;
            $display("FAIL load_use_release got=%b st=%0d want=%b st=0", obs, dut.state_q, E_NONE);
        end
        step();
    endtask

    task automatic test_fetch_wait();
        apply_reset();
        // Fetch stall outranks a simultaneous load-use.
        set_in(1, 0, 0, 0, 0, 0, 1, 0);
        #4;
        checks++;
        if (obs !== E_IF) begin
            failures++;
            $display("FAIL fetch_wait got=%b want=%b", obs, E_IF);
        end
        step();
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE) begin
            failures++;
            $display("FAIL fetch_ok got=%b want=%b", obs, E_NONE);
        end
        step();
    endtask

    task automatic test_data_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0, 0, 0, 0, 0);
            #4;
            checks++;
            if (obs !== E_MEM) begin
                failures++;
                $display("FAIL data_wait_c%0d got=%b want=%b", i, obs, E_MEM);
            end
            step();
        end
        set_in(0, 0, 1, 1, 0, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE) begin
            failures++;
            $display("FAIL data_ok got=%b want=%b", obs, E_NONE);
        end
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE || dut.state_q !== 2'd0) begin
            failures++;
            $display("FAIL data_after got=%b st=%0d want=%b st=0", obs, dut.state_q, E_NONE);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (MemStallCnt !== 3'd3 || StallCnt !== 3'd3) begin
            failures++;
            $display("FAIL data_counters got=%0d/%0d want=3/3", MemStallCnt, StallCnt);
        end
`endif
        step();
    endtask

    task automatic test_divide();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            set_in(0, 0, 0, 0, 1, 0, 0, 0);
            #4;
            checks++;
            if (obs !== E_DIV) begin
                failures++;
                $display("FAIL div_wait_c%0d got=%b want=%b", i, obs, E_DIV);
            end
            step();
        end
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE) begin
            failures++;
            $display("FAIL div_done got=%b want=%b", obs, E_NONE);
        end
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE || dut.state_q !== 2'd0) begin
            failures++;
            $display("FAIL div_after got=%b st=%0d want=%b st=0", obs, dut.state_q, E_NONE);
        end
        step();
    endtask

    task automatic test_load_then_div();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 1, 0, 1, 0, 0, 0);
            #4;
            checks++;
            if (obs !== E_MEM) begin
                failures++;
                $display("FAIL ld_div_mem_c%0d got=%b want=%b", i, obs, E_MEM);
            end
            step();
        end
        set_in(0, 0, 1, 1, 1, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_DIV) begin
            failures++;
            $display("FAIL ld_div_handoff got=%b want=%b", obs, E_DIV);
        end
        step();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_DIV || dut.state_q !== 2'd2) begin
            failures++;
            $display("FAIL ld_div_wait got=%b st=%0d want=%b st=2", obs, dut.state_q, E_DIV);
        end
        step();
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE) begin
            failures++;
            $display("FAIL ld_div_done got=%b want=%b", obs, E_NONE);
        end
        step();
    endtask

    task automatic test_exc_vs_mem();
        apply_reset();
        set_in(0, 0, 1, 0, 1, 0, 1, 1);
        #4;
        checks++;
        if (obs !== E_EXC) begin
            failures++;
            $display("FAIL exc_vs_mem got=%b want=%b", obs, E_EXC);
        end
        step();
        // The kill cycle ignores all requests.
        set_in(1, 0, 1, 0, 1, 0, 1, 0);
        #4;
        checks++;
        if (obs !== E_KILL) begin
            failures++;
            $display("FAIL exc_flush got=%b want=%b", obs, E_KILL);
        end
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE || dut.state_q !== 2'd0) begin
            failures++;
            $display("FAIL exc_after got=%b st=%0d want=%b st=0", obs, dut.state_q, E_NONE);
        end
        step();
    endtask

    task automatic test_reset_mid_div();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 1, 0, 0, 0);
            #4;
            checks++;
            if (obs !== E_DIV) begin
                failures++;
                $display("FAIL rst_div_c%0d got=%b want=%b", i, obs, E_DIV);
            end
            step();
        end
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== E_NONE || dut.state_q !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_div got=%b st=%0d want=%b st=0", obs, dut.state_q, E_NONE);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (StallCnt !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid_div_cnt got=%0d want=0", StallCnt);
        end
`endif
        step();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (obs !== E_NONE) begin
            failures++;
            $display("FAIL rst_div_abandon got=%b want=%b", obs, E_NONE);
        end
        step();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (StallCnt !== 3'd7) begin
            failures++;
            $display("FAIL cnt_all_ones got=%0d want=7", StallCnt);
        end
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (StallCnt !== 3'd0) begin
            failures++;
            $display("FAIL cnt_wrap got=%0d want=0", StallCnt);
        end
        step();
    endtask
`endif

    task automatic test_random();
        logic [8:0] exp;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
            #4;
            model_eval(exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random_c%0d got=%b want=%b", i, obs, exp);
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (StallCnt !== m_scnt || MemStallCnt !== m_mcnt) begin
                failures++;
                $display("FAIL random_cnt_c%0d got=%0d/%0d want=%0d/%0d",
                         i, StallCnt, MemStallCnt, m_scnt, m_mcnt);
            end
            m_scnt = m_scnt + {2'b0, exp[8]};
            m_mcnt = m_mcnt + {2'b0, exp[5]};
`endif
            step();
            m_mem = n_mem; m_div = n_div; m_kill = n_kill;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fetch_wait();
        test_data_wait();
        test_divide();
        test_load_then_div();
        test_exc_vs_mem();
        test_reset_mid_div();
`ifdef PIPE_PERF_CNT_EN
        test_counter_wrap();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
